// File: rtl/svc_rv_ras.sv
// Return address stack: speculative push/pop from the front end with
// checkpoint repair from MEM. Circular flop storage, so overflow
// silently overwrites the oldest entry.
module svc_rv_ras #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             push_en,
  input  logic [XLEN-1:0]  push_addr,
  input  logic             pop_en,
  input  logic             restore_en,
  input  logic [PTR_W-1:0] restore_ptr,
  input  logic [CNT_W-1:0] restore_cnt,
  input  logic [XLEN-1:0]  restore_top,
  output logic             ras_valid,
  output logic [XLEN-1:0]  ras_target,
  output logic [PTR_W-1:0] ckpt_ptr,
  output logic [CNT_W-1:0] ckpt_cnt,
  output logic [XLEN-1:0]  ckpt_top
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [XLEN-1:0]  mem_d [DEPTH];

  // Next-state: restore beats stall, stall beats push/pop.
  always_comb begin
    tos_d = tos_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (restore_en) begin
      tos_d              = restore_ptr;
      cnt_d              = restore_cnt;
      mem_d[restore_ptr] = restore_top;
    end else if (!stall) begin
      if (push_en && pop_en) begin
        // Pop-then-push collapses to overwriting the current top.
        mem_d[tos_q] = push_addr;
        if (cnt_q == '0) cnt_d = CNT_ONE;
      end else if (push_en) begin
        tos_d                  = tos_q + PTR_ONE;
        mem_d[tos_q + PTR_ONE] = push_addr;
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_ONE;
      end else if (pop_en && (cnt_q != '0)) begin
        tos_d = tos_q - PTR_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // State registers; reset clears pointer, count and every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  // Prediction and checkpoint views of the current top.
  always_comb begin
    ras_valid  = (cnt_q != '0);
    ras_target = mem_q[tos_q];
    ckpt_ptr   = tos_q;
    ckpt_cnt   = cnt_q;
    ckpt_top   = mem_q[tos_q];
  end

  // A checkpointed occupancy can never exceed the stack depth.
  a_restore_cnt_legal : assert property (
    @(posedge clk) disable iff (!rst_n) restore_en |-> (restore_cnt <= CNT_FULL)
  );

endmodule
